mem_port_arbiter: RTL and testbench

- Shares one single-ported synchronous memory between instruction fetch and the execute-stage load/store path.
- Arbitrates requests cycle by cycle; data accesses have priority.
- A starvation counter guarantees forward progress for fetch.
- Tracks outstanding reads so it can route the one-cycle-latency read data back and raise per-requester stalls.

---
 rtl/mem_port_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/load-store arbiter for one single-ported synchronous memory
//
// Purpose: shares one memory port between instruction fetch and the execute-stage
// load/store path. Data wins by default. A saturating starvation counter forces a
// fetch through after STARVE_LIMIT consecutive data grants that left fetch waiting.
// A registered owner code routes the one-cycle-latency read data back as rvalid.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   instr_req_i/addr_i              fetch word-read request and byte address
//   instr_gnt_o/rvalid_o/rdata_o    fetch grant, read-data valid, read data
//   data_req_i/we_i/addr_i/wdata_i  load/store request, byte enables, address, store data
//   data_gnt_o/rvalid_o/rdata_o     load/store grant, read-data valid, read data
//   mem_en_o/we_o/addr_o/wdata_o    memory command (word-aligned address)
//   mem_rdata_i                     memory read data, one cycle after a read enable
//   fetch_stall_o, data_stall_o     requester must hold its request
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  input  logic        data_req_i,
  input  logic [3:0]  data_we_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        mem_en_o,
  output logic [3:0]  mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  output logic        fetch_stall_o,
  output logic        data_stall_o
);

  typedef enum logic [1:0] {
    OWN_IDLE    = 2'd0,
    OWN_INSTR   = 2'd1,
    OWN_DATA_RD = 2'd2
  } owner_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  owner_e      owner_q, owner_d;
  logic [3:0]  starve_cnt, starve_cnt_d;
  logic        force_instr;
  logic [31:0] sel_addr;

  // Fetch is forced through only when it is actually contending with data.
  assign force_instr = (starve_cnt == LIMIT) & instr_req_i & data_req_i;

  always_comb begin
    instr_gnt_o = instr_req_i & ~data_req_i;
    data_gnt_o  = data_req_i;
    if (force_instr) begin
      instr_gnt_o = 1'b1;
      data_gnt_o  = 1'b0;
    end
  end

  always_comb begin
    sel_addr    = 32'h0;
    mem_we_o    = 4'b0000;
    mem_wdata_o = 32'h0;
    if (data_gnt_o) begin
      sel_addr    = data_addr_i;
      mem_we_o    = data_we_i;
      mem_wdata_o = data_wdata_i;
    end else if (instr_gnt_o) begin
      sel_addr = instr_addr_i;
    end
  end

  assign mem_en_o   = instr_gnt_o | data_gnt_o;
  assign mem_addr_o = sel_addr & ~32'h3;

  assign fetch_stall_o = instr_req_i & ~instr_gnt_o;
  assign data_stall_o  = data_req_i & ~data_gnt_o;

  // Owner code is the registered grant; writes map to IDLE so they raise no rvalid.
  always_comb begin
    owner_d = OWN_IDLE;
    if (instr_gnt_o) begin
      owner_d = OWN_INSTR;
    end else if (data_gnt_o && (data_we_i == 4'b0000)) begin
      owner_d = OWN_DATA_RD;
    end
  end

  // Counts data grants that bypassed a waiting fetch; any fetch grant or an idle
  // fetch side clears it.
  always_comb begin
    starve_cnt_d = starve_cnt;
    if (instr_gnt_o || !instr_req_i) begin
      starve_cnt_d = 4'd0;
    end else if (data_gnt_o && (starve_cnt != LIMIT)) begin
      starve_cnt_d = starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q    <= OWN_IDLE;
      starve_cnt <= 4'd0;
    end else begin
      owner_q    <= owner_d;
      starve_cnt <= starve_cnt_d;
    end
  end

  assign instr_rvalid_o = (owner_q == OWN_INSTR);
  assign data_rvalid_o  = (owner_q == OWN_DATA_RD);
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o, instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        data_req_i;
  logic [3:0]  data_we_i;
  logic [31:0] data_addr_i, data_wdata_i;
  logic        data_gnt_o, data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        mem_en_o;
  logic [3:0]  mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [31:0] mem_rdata_i = 32'h0;
  logic        fetch_stall_o, data_stall_o;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    bit          chk;
    logic        ig, dg, en;
    logic [3:0]  we;
    logic [31:0] addr, wdata;
    logic        fs, ds;
  } comb_t;

  typedef struct {
    int          due;
    bit          is_instr;
    logic [31:0] data;
  } rsp_t;

  comb_t cq[$];
  rsp_t  rq[$];

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
    .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_addr_i(data_addr_i),
    .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
    .data_rdata_o(data_rdata_o), .mem_en_o(mem_en_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .fetch_stall_o(fetch_stall_o), .data_stall_o(data_stall_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // Memory model: returns a known pattern for the address it was handed.
  always @(posedge clk) begin
    if (mem_en_o && mem_we_o == 4'b0000) mem_rdata_i <= mem_word(mem_addr_o);
    else                                 mem_rdata_i <= 32'hDEAD_BEEF;
  end

  task automatic step(input logic rst, input logic ir, input logic [31:0] ia,
                      input logic dr, input logic [3:0] we, input logic [31:0] da,
                      input logic [31:0] wd, input logic eig, input logic edg);
    comb_t c;
    rsp_t  r;
    @(posedge clk);
    #1;
    reset = rst; instr_req_i = ir; instr_addr_i = ia;
    data_req_i = dr; data_we_i = we; data_addr_i = da; data_wdata_i = wd;
    c.chk   = !rst;
    c.ig    = eig;
    c.dg    = edg;
    c.en    = eig | edg;
    c.we    = edg ? we : 4'b0000;
    c.wdata = edg ? wd : 32'h0;
    c.addr  = edg ? {da[31:2], 2'b00} : (eig ? {ia[31:2], 2'b00} : 32'h0);
    c.fs    = ir & ~eig;
    c.ds    = dr & ~edg;
    cq.push_back(c);
    if (!rst && eig) begin
      r.due = cyc + 1; r.is_instr = 1'b1; r.data = mem_word({ia[31:2], 2'b00});
      rq.push_back(r);
    end
    if (!rst && edg && we == 4'b0000) begin
      r.due = cyc + 1; r.is_instr = 1'b0; r.data = mem_word({da[31:2], 2'b00});
      rq.push_back(r);
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic both(input logic [31:0] ia, input logic [31:0] da, input logic eig);
    step(1'b0, 1'b1, ia, 1'b1, 4'h0, da, 32'h0, eig, ~eig);
  endtask

  // Monitor: compares combinational outputs every cycle and pops read responses
  // whenever the DUT raises an rvalid.
  initial begin
    comb_t c;
    rsp_t  r;
    forever begin
      @(negedge clk);
      if (cq.size() > 0) begin
        c = cq.pop_front();
        if (c.chk) begin
          checks++;
          if ({instr_gnt_o, data_gnt_o} !== {c.ig, c.dg}) begin
            errors++;
            $display("FAIL grant cyc=%0d got ig=%b dg=%b want ig=%b dg=%b",
                     cyc, instr_gnt_o, data_gnt_o, c.ig, c.dg);
          end
          checks++;
          if ({mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o} !== {c.en, c.we, c.addr, c.wdata}) begin
            errors++;
            $display("FAIL mem cyc=%0d got en=%b we=%b addr=%h wd=%h want en=%b we=%b addr=%h wd=%h",
                     cyc, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, c.en, c.we, c.addr, c.wdata);
          end
          checks++;
          if ({fetch_stall_o, data_stall_o} !== {c.fs, c.ds}) begin
            errors++;
            $display("FAIL stall cyc=%0d got fs=%b ds=%b want fs=%b ds=%b",
                     cyc, fetch_stall_o, data_stall_o, c.fs, c.ds);
          end
        end
      end
      if (instr_rvalid_o === 1'b1 || data_rvalid_o === 1'b1) begin
        checks++;
        if (instr_rvalid_o === 1'b1 && data_rvalid_o === 1'b1) begin
          errors++;
          $display("FAIL rvalid_both cyc=%0d got both rvalid high want at most one", cyc);
        end else if (rq.size() == 0) begin
          errors++;
          $display("FAIL rvalid_unexpected cyc=%0d got irv=%b drv=%b want none",
                   cyc, instr_rvalid_o, data_rvalid_o);
        end else begin
          r = rq.pop_front();
          if (r.due != cyc || instr_rvalid_o !== r.is_instr) begin
            errors++;
            $display("FAIL rvalid_route cyc=%0d got irv=%b drv=%b want instr=%b at cyc %0d",
                     cyc, instr_rvalid_o, data_rvalid_o, r.is_instr, r.due);
          end
          checks++;
          if ((r.is_instr ? instr_rdata_o : data_rdata_o) !== r.data) begin
            errors++;
            $display("FAIL rdata cyc=%0d got %h want %h", cyc,
                     r.is_instr ? instr_rdata_o : data_rdata_o, r.data);
          end
        end
      end else if (rq.size() > 0 && rq[0].due <= cyc) begin
        checks++;
        errors++;
        $display("FAIL rvalid_missing cyc=%0d got none want instr=%b", cyc, rq[0].is_instr);
        void'(rq.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b1; instr_req_i = 1'b0; instr_addr_i = 32'h0;
    data_req_i = 1'b0; data_we_i = 4'h0; data_addr_i = 32'h0; data_wdata_i = 32'h0;
    step(1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    idle();
    idle();

    // Fetch only, three cycles at 0x100.
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 32'h100, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Contention: unaligned data read wins, fetch stalls.
    both(32'h104, 32'h2003, 1'b0);
    idle();

    // Continuous contention: D,D,D,D,I,D.
    both(32'h108, 32'h3004, 1'b0);
    both(32'h108, 32'h3004, 1'b0);
    both(32'h108, 32'h3004, 1'b0);
    both(32'h108, 32'h3004, 1'b0);
    both(32'h108, 32'h3004, 1'b1);
    both(32'h10C, 32'h3004, 1'b0);
    idle();

    // Byte store: no read response.
    step(1'b0, 1'b0, 32'h0, 1'b1, 4'b0100, 32'h40, 32'h00AB00AB, 1'b0, 1'b1);
    idle();

    // Store under contention still stalls fetch.
    step(1'b0, 1'b1, 32'h110, 1'b1, 4'b1111, 32'h44, 32'h12345678, 1'b0, 1'b1);
    idle();

    // Alternating fetch/data reads, back to back.
    step(1'b0, 1'b1, 32'h200, 1'b0, 4'h0, 32'h0,   32'h0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'h0,   1'b1, 4'h0, 32'h304, 32'h0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 32'h208, 1'b0, 4'h0, 32'h0,   32'h0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'h0,   1'b1, 4'h0, 32'h30E, 32'h0, 1'b0, 1'b1);
    idle();

    // Build starvation to 3, reset during a granted read, then the full
    // four-deep data run must repeat before fetch gets through.
    both(32'h400, 32'h500, 1'b0);
    both(32'h400, 32'h500, 1'b0);
    both(32'h400, 32'h500, 1'b0);
    step(1'b1, 1'b1, 32'h400, 1'b1, 4'h0, 32'h500, 32'h0, 1'b0, 1'b1);
    both(32'h400, 32'h504, 1'b0);
    both(32'h400, 32'h504, 1'b0);
    both(32'h400, 32'h504, 1'b0);
    both(32'h400, 32'h504, 1'b0);
    both(32'h400, 32'h504, 1'b1);
    idle();
    idle();
    idle();

    @(negedge clk);
    #1;
    checks++;
    if (rq.size() != 0) begin
      errors++;
      $display("FAIL rsp_drain got %0d pending responses want 0", rq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
